// File: rtl/fifo_read_logic.sv
// FIFO read-side controller: read pointer, occupancy count, registered read data
// with one-cycle latency, occupancy flags and a sticky underflow flag.
module fifo_read_logic #(
    parameter int MEM_SIZE     = 4,
    parameter int WORD_SIZE    = 6,
    parameter int PTR_L        = 5,
    parameter int ALMOST_EMPTY = 1,
    parameter int ALMOST_FULL  = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_rd,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [PTR_L-1:0]     rd_ptr,
    output logic                 pop,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 fifo_almost_empty,
    output logic                 fifo_almost_full,
    output logic                 err_underflow
);

    localparam logic [PTR_L-1:0] CNT_MAX  = PTR_L'(MEM_SIZE);
    localparam logic [PTR_L-1:0] PTR_LAST = PTR_L'(MEM_SIZE - 1);
    localparam logic [PTR_L-1:0] AE_LVL   = PTR_L'(ALMOST_EMPTY);
    localparam logic [PTR_L-1:0] AF_LVL   = PTR_L'(ALMOST_FULL);

    logic [PTR_L-1:0]     count_p0;
    logic [PTR_L-1:0]     rd_ptr_p0;
    logic [WORD_SIZE-1:0] data_p1;
    logic                 vld_p1;
    logic                 err_p0;

    // Occupancy update: a push into a full FIFO is dropped, a simultaneous
    // push and pop cancel out.
    function automatic logic [PTR_L-1:0] sat_count(input logic [PTR_L-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
        if (inc && !dec)
            return (cnt == CNT_MAX) ? cnt : cnt + PTR_L'(1);
        if (dec && !inc)
            return (cnt == '0) ? cnt : cnt - PTR_L'(1);
        return cnt;
    endfunction

    function automatic logic [PTR_L-1:0] wrap_inc(input logic [PTR_L-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_L'(1);
    endfunction

    assign fifo_empty        = (count_p0 == '0);
    assign fifo_full         = (count_p0 == CNT_MAX);
    assign fifo_almost_empty = (count_p0 <= AE_LVL);
    assign fifo_almost_full  = (count_p0 >= AF_LVL);

    assign pop = reset_L & fifo_rd & ~fifo_empty;

    // p0 -> p1: read data captured on pop, valid follows one cycle later
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count_p0  <= '0;
            rd_ptr_p0 <= '0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            err_p0    <= 1'b0;
        end else begin
            count_p0 <= sat_count(count_p0, push, pop);
            vld_p1   <= pop;
            if (pop) begin
                rd_ptr_p0 <= wrap_inc(rd_ptr_p0);
                data_p1   <= mem_data;
            end
            if (fifo_rd && fifo_empty)
                err_p0 <= 1'b1;
        end
    end

    assign rd_ptr        = rd_ptr_p0;
    assign data_out      = data_p1;
    assign valid_out     = vld_p1;
    assign err_underflow = err_p0;

endmodule

// File: doc/fifo_read_logic.md
FIFO_READ_LOGIC -- requirements
Module: fifo_read_logic

Interface
REQ-001 Parameter MEM_SIZE, default 4, is the number of FIFO entries.
REQ-002 Parameter WORD_SIZE, default 6, is the data word width in bits.
REQ-003 Parameter PTR_L, default 5, is the read-pointer and occupancy-count width; it SHALL be able to hold the value MEM_SIZE.
REQ-004 Parameter ALMOST_EMPTY, default 1, is the occupancy at or below which fifo_almost_empty asserts.
REQ-005 Parameter ALMOST_FULL, default 3, is the occupancy at or above which fifo_almost_full asserts.
REQ-006 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-007 reset_L  input  1  is the asynchronous, active-low reset.
REQ-008 fifo_rd  input  1  is the consumer read request.
REQ-009 push  input  1  is the accepted-write strobe from the write side; it indicates that one word is written this cycle.
REQ-010 mem_data  input  WORD_SIZE  is the memory read-port data at address rd_ptr.
REQ-011 rd_ptr  output  PTR_L  is the memory read address.
REQ-012 pop  output  1  is the accepted-read strobe (combinational).
REQ-013 data_out  output  WORD_SIZE  is the registered read data.
REQ-014 valid_out  output  1  marks data_out as new this cycle.
REQ-015 fifo_empty, fifo_full, fifo_almost_empty, fifo_almost_full  output  1 each  are the occupancy flags.
REQ-016 err_underflow  output  1  is a sticky flag that records a read attempted while empty.

Function
REQ-017 pop SHALL be 1 exactly when reset_L=1, fifo_rd=1 and fifo_empty=0; otherwise pop SHALL be 0.
REQ-018 On a clock edge with pop=1, rd_ptr SHALL advance by 1, and SHALL wrap from MEM_SIZE-1 to 0; otherwise rd_ptr SHALL hold.
REQ-019 On a clock edge with pop=1, data_out SHALL load mem_data and valid_out SHALL be 1 for the following cycle (1-cycle read latency).
REQ-020 On a clock edge with pop=0, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-021 The occupancy count SHALL update per edge as follows: push only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-022 The count SHALL saturate at MEM_SIZE: a push when the count is already MEM_SIZE is ignored, and the count never exceeds MEM_SIZE or drops below 0.
REQ-023 fifo_empty SHALL equal (count==0) and fifo_full SHALL equal (count==MEM_SIZE); both are combinational from the count register.
REQ-024 fifo_almost_empty SHALL equal (count<=ALMOST_EMPTY) and fifo_almost_full SHALL equal (count>=ALMOST_FULL).
REQ-025 Simultaneous push and fifo_rd while the FIFO is empty: pop=0 and the count becomes 1; the word becomes readable from the next cycle.
REQ-026 Simultaneous push and pop while the FIFO is non-empty: the count is unchanged and rd_ptr advances.
REQ-027 err_underflow SHALL set on any edge where fifo_rd=1 and fifo_empty=1, and SHALL clear only on reset.
REQ-028 fifo_full SHALL be the flag the write side uses to block writes.

Reset
REQ-029 While reset_L=0, regardless of clk: rd_ptr=0, count=0, data_out=0, valid_out=0, err_underflow=0, pop=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0.
REQ-030 Reset asserted mid-operation SHALL immediately discard any pending valid_out and any stored occupancy.
REQ-031 After reset_L rises, the first state change SHALL occur on the next rising clk edge.

Verification
REQ-032 Reset, then 4 push cycles, then fifo_rd for 4 cycles with mem_data=A,B,C,D -> rd_ptr steps 0,1,2,3,0; valid_out is high 1 cycle after each pop; data_out follows A..D; fifo_empty=1 at the end.
REQ-033 Fill to 4 (defaults) -> fifo_full=1 and fifo_almost_full=1; one more push -> the count stays 4.
REQ-034 Empty FIFO, fifo_rd=1 for 1 cycle -> pop=0, rd_ptr=0, err_underflow=1 and it stays 1 until reset.
REQ-035 Empty FIFO with push=1 and fifo_rd=1 in the same cycle -> count=1, no valid_out; fifo_rd in the next cycle -> pop=1 and valid_out 1 cycle later.
REQ-036 Count=2 with push=1 and fifo_rd=1 held for 6 cycles -> the count stays 2 and rd_ptr wraps 3->0.
REQ-037 reset_L driven low between clock edges while valid_out=1 and count=3 -> valid_out=0, count=0 and rd_ptr=0 without waiting for a clk edge.
